fm_coord_pipe: RTL and testbench

//  Parametrised feature-map coordinate delay pipeline; successor to the fixed coordinate shift register.

---
 rtl/fm_coord_pipe_pkg.sv | 18 +
 rtl/fm_coord_stage.sv | 40 ++++
 rtl/fm_coord_pipe.sv | 127 ++++++++++++
 tb/tb_fm_coord_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fm_coord_pipe_pkg.sv
// Shared constants for the feature-map coordinate pipeline.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
// Coordinate widths and pipe depths used by the mult-adder controller and the
// fm writeback. The parameter defaults of fm_coord_pipe derive from these.
package fm_coord_pipe_pkg;

   localparam int X_COORD_BITWIDTH   = 4;
   localparam int Y_COORD_BITWIDTH   = 4;
   localparam int FM_COORD_SR_DEPTH  = 8;
   localparam int FM_COORD_DEF_DEPTH = 8;

   // Width needed to hold a count from 0 up to max_depth inclusive.
   function automatic int occ_width(input int max_depth);
      return $clog2(max_depth + 1);
   endfunction

endpackage

// File: rtl/fm_coord_stage.sv
// One {vld,x,y,last} stage of the coordinate delay pipe.
// Latency: 1 enabled cycle.
// Backpressure: en=0 holds the stage; flush clears vld only and wins over en.
// Ports: clock, reset (sync, active-low), en, flush,
//        nxt_vld/nxt_x/nxt_y/nxt_last (value to load), vld/x/y/last (stage contents).
module fm_coord_stage #(
   parameter int X_W = 5,
   parameter int Y_W = 5
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           en,
   input  logic           flush,
   input  logic           nxt_vld,
   input  logic [X_W-1:0] nxt_x,
   input  logic [Y_W-1:0] nxt_y,
   input  logic           nxt_last,
   output logic           vld,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         vld  <= 1'b0;
         x    <= '0;
         y    <= '0;
         last <= 1'b0;
      end else if (flush) begin
         vld  <= 1'b0;
      end else if (en) begin
         vld  <= nxt_vld;
         x    <= nxt_x;
         y    <= nxt_y;
         last <= nxt_last;
      end
   end

endmodule

// File: rtl/fm_coord_pipe.sv
// Coordinate delay pipe carrying (x,y,last) alongside the mult-adder datapath.
// Latency: depth_cur enabled cycles (runtime selectable, 1..MAX_DEPTH).
// Backpressure: en=0 stalls every stage; in_valid is dropped while stalled.
// Ports: clock, reset (sync, active-low), en, flush, in_valid/x_coord/y_coord/in_last,
//        cfg_load/depth_sel (depth change, only when empty), fm_valid/fm_x_coord/
//        fm_y_coord/fm_last (tap at depth_cur-1), frame_done, occupancy, empty,
//        cfg_err, depth_cur.
module fm_coord_pipe
   import fm_coord_pipe_pkg::*;
#(
   parameter int X_W       = X_COORD_BITWIDTH + 1,
   parameter int Y_W       = Y_COORD_BITWIDTH + 1,
   parameter int MAX_DEPTH = FM_COORD_SR_DEPTH,
   parameter int DEF_DEPTH = FM_COORD_DEF_DEPTH,
   parameter int OCC_W     = occ_width(MAX_DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [X_W-1:0]   x_coord,
   input  logic [Y_W-1:0]   y_coord,
   input  logic             in_last,
   input  logic             cfg_load,
   input  logic [OCC_W-1:0] depth_sel,
   output logic             fm_valid,
   output logic [X_W-1:0]   fm_x_coord,
   output logic [Y_W-1:0]   fm_y_coord,
   output logic             fm_last,
   output logic             frame_done,
   output logic [OCC_W-1:0] occupancy,
   output logic             empty,
   output logic             cfg_err,
   output logic [OCC_W-1:0] depth_cur
);

   logic           s_vld  [MAX_DEPTH];
   logic [X_W-1:0] s_x    [MAX_DEPTH];
   logic [Y_W-1:0] s_y    [MAX_DEPTH];
   logic           s_last [MAX_DEPTH];

   for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
      logic           nv;
      logic [X_W-1:0] nx;
      logic [Y_W-1:0] ny;
      logic           nl;

      if (i == 0) begin : g_head
         assign nv = in_valid;
         assign nx = x_coord;
         assign ny = y_coord;
         assign nl = in_last;
      end else begin : g_body
         // Stages past the tap keep shifting data but their valid tag is
         // killed. Otherwise entries that already left at a short depth would
         // linger there and reappear at the tap after a later depth increase.
         assign nv = s_vld[i-1] & (OCC_W'(i) < depth_cur);
         assign nx = s_x[i-1];
         assign ny = s_y[i-1];
         assign nl = s_last[i-1];
      end

      fm_coord_stage #(.X_W(X_W), .Y_W(Y_W)) u_stage (
         .clock    (clock),
         .reset    (reset),
         .en       (en),
         .flush    (flush),
         .nxt_vld  (nv),
         .nxt_x    (nx),
         .nxt_y    (ny),
         .nxt_last (nl),
         .vld      (s_vld[i]),
         .x        (s_x[i]),
         .y        (s_y[i]),
         .last     (s_last[i])
      );
   end

   // Output tap: stage depth_cur-1, straight from the stage registers.
   always_comb begin
      fm_valid   = 1'b0;
      fm_x_coord = '0;
      fm_y_coord = '0;
      fm_last    = 1'b0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (depth_cur == OCC_W'(i + 1)) begin
            fm_valid   = s_vld[i];
            fm_x_coord = s_x[i];
            fm_y_coord = s_y[i];
            fm_last    = s_last[i];
         end
      end
   end

   logic depth_ok;
   logic cfg_accept;

   assign empty      = (occupancy == '0);
   assign depth_ok   = (depth_sel != '0) && (depth_sel <= OCC_W'(MAX_DEPTH));
   assign cfg_accept = cfg_load & empty & depth_ok & ~flush;

   always_ff @(posedge clock) begin
      if (!reset) begin
         depth_cur  <= OCC_W'(DEF_DEPTH);
         occupancy  <= '0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         frame_done <= en & fm_valid & fm_last & ~flush;
         cfg_err    <= cfg_load & ~cfg_accept;
         if (cfg_accept) begin
            depth_cur <= depth_sel;
         end
         if (flush) begin
            occupancy <= '0;
         end else if (en) begin
            case ({in_valid, fm_valid})
               2'b10:   occupancy <= occupancy + OCC_W'(1);
               2'b01:   occupancy <= occupancy - OCC_W'(1);
               default: occupancy <= occupancy;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fm_coord_pipe.sv
// Testbench for fm_coord_pipe: scoreboard of expected coordinates with due times.
// Each entry records the enabled-cycle count at which it must sit on the tap.
// Occupancy, valid, frame_done, cfg_err and depth are checked every cycle.
module tb_fm_coord_pipe;

   localparam int XW    = 5;
   localparam int YW    = 5;
   localparam int MAXD  = 8;
   localparam int DEFD  = 8;
   localparam int OCCW  = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            en = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic [XW-1:0]   x_coord = '0;
   logic [YW-1:0]   y_coord = '0;
   logic            in_last = 1'b0;
   logic            cfg_load = 1'b0;
   logic [OCCW-1:0] depth_sel = '0;
   logic            fm_valid;
   logic [XW-1:0]   fm_x_coord;
   logic [YW-1:0]   fm_y_coord;
   logic            fm_last;
   logic            frame_done;
   logic [OCCW-1:0] occupancy;
   logic            empty;
   logic            cfg_err;
   logic [OCCW-1:0] depth_cur;

   always #5 clock = ~clock;

   fm_coord_pipe #(
      .X_W(XW), .Y_W(YW), .MAX_DEPTH(MAXD), .DEF_DEPTH(DEFD), .OCC_W(OCCW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .flush      (flush),
      .in_valid   (in_valid),
      .x_coord    (x_coord),
      .y_coord    (y_coord),
      .in_last    (in_last),
      .cfg_load   (cfg_load),
      .depth_sel  (depth_sel),
      .fm_valid   (fm_valid),
      .fm_x_coord (fm_x_coord),
      .fm_y_coord (fm_y_coord),
      .fm_last    (fm_last),
      .frame_done (frame_done),
      .occupancy  (occupancy),
      .empty      (empty),
      .cfg_err    (cfg_err),
      .depth_cur  (depth_cur)
   );

   typedef struct {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          last;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   en_cnt   = 0;
   int   depth_m  = DEFD;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Advance the model by one clock using the currently driven inputs, then
   // clock the DUT and compare its registered state against the model.
   task automatic tick();
      logic pop, efd, eerr, acc;
      int   nd;
      exp_t e;
      pop = 1'b0; efd = 1'b0; eerr = 1'b0;
      if (!reset) begin
         sb.delete();
         depth_m = DEFD;
      end else begin
         pop = en && !flush && sb.size() > 0 && sb[0].due == en_cnt;
         if (pop) begin
            check("out_x", fm_x_coord, sb[0].x);
            check("out_y", fm_y_coord, sb[0].y);
            check("out_last", fm_last, sb[0].last);
            efd = sb[0].last;
         end
         acc  = cfg_load && sb.size() == 0 && depth_sel >= 1 && depth_sel <= MAXD && !flush;
         eerr = cfg_load && !acc;
         nd   = acc ? int'(depth_sel) : depth_m;
         if (flush) begin
            sb.delete();
         end else if (en) begin
            if (pop) void'(sb.pop_front());
            if (in_valid) begin
               e.x = x_coord; e.y = y_coord; e.last = in_last; e.due = en_cnt + nd;
               sb.push_back(e);
            end
            en_cnt++;
         end
         depth_m = nd;
      end
      @(posedge clock);
      #1;
      check("occupancy", occupancy, sb.size());
      check("fm_valid", fm_valid, (sb.size() > 0 && sb[0].due == en_cnt));
      check("empty", empty, sb.size() == 0);
      check("frame_done", frame_done, efd);
      check("cfg_err", cfg_err, eerr);
      check("depth_cur", depth_cur, depth_m);
   endtask

   task automatic cyc(input logic e, input logic v, input int x, input int y, input logic l);
      en = e; in_valid = v; x_coord = XW'(x); y_coord = YW'(y); in_last = l;
      tick();
      in_valid = 1'b0; in_last = 1'b0; cfg_load = 1'b0; flush = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic load(input int d);
      cfg_load = 1'b1; depth_sel = OCCW'(d);
   endtask

   initial begin
      // Reset state
      reset = 1'b0;
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      check("rst_x", fm_x_coord, 0);
      check("rst_y", fm_y_coord, 0);
      check("rst_last", fm_last, 0);
      check("rst_empty", empty, 1);
      check("rst_depth", depth_cur, DEFD);
      reset = 1'b1;

      // Single entry at default depth 8
      cyc(1'b1, 1'b1, 3, 4, 1'b0);
      idle(10);

      // Stream with en toggling; stall cycles carry junk that must be dropped
      for (int i = 0; i < 30; i++) begin
         if (i % 2 == 0) cyc(1'b1, i < 10, i / 2, i / 2, 1'b0);
         else            cyc(1'b0, 1'b1, 31, 31, 1'b0);
      end

      // Flush with 3 in flight, then a fresh entry
      cyc(1'b1, 1'b1, 1, 1, 1'b0);
      cyc(1'b1, 1'b1, 2, 2, 1'b0);
      cyc(1'b1, 1'b1, 3, 3, 1'b0);
      flush = 1'b1;
      cyc(1'b1, 1'b1, 7, 7, 1'b0);
      cyc(1'b1, 1'b1, 9, 9, 1'b0);
      idle(10);

      // Depth configuration
      load(3); cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b1, 5, 6, 1'b0);
      load(5); cyc(1'b1, 1'b0, 0, 0, 1'b0);
      idle(4);
      load(0); cyc(1'b1, 1'b0, 0, 0, 1'b0);
      load(9); cyc(1'b1, 1'b0, 0, 0, 1'b0);
      load(4); flush = 1'b1; cyc(1'b1, 1'b0, 0, 0, 1'b0);
      load(4); cyc(1'b1, 1'b1, 8, 9, 1'b0);
      idle(6);

      // frame_done at depth 2, including a stall with last on the tap
      load(2); cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b1, 4, 4, 1'b1);
      idle(5);
      cyc(1'b1, 1'b1, 2, 3, 1'b1);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 0, 0, 1'b0);
      idle(4);

      // Reset with 5 in flight at a non-default depth
      load(6); cyc(1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 10 + i, 20 + i, 1'b1);
      check("pre_rst_occ", occupancy, 5);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      reset = 1'b1;
      check("rst2_x", fm_x_coord, 0);
      check("rst2_y", fm_y_coord, 0);
      check("rst2_last", fm_last, 0);
      check("rst2_depth", depth_cur, DEFD);
      idle(12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
